uart_receiver: RTL
==================

Name: uart_receiver

Overview:
- UART receive path: deserialises an asynchronous serial line into parallel words using an external oversampling tick (16 ticks per bit).
- Pairs with the team's UART transmitter, sharing its baud-tick generator, frame format (1 start, Nbits data LSB-first, 1 stop) and Nbits/Sticks parameters.
- Sits between the pad-level rx line and the byte-consumer logic.

Parameters:
- Nbits, 8, data bits per frame; legal range 5..8.
- Sticks, 16, ticks counted in stop state before stop-bit sample; legal range 1..16.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous reset, active-low
- rx_i  input  1  serial line, idle high, asynchronous to clk_i
- tick_i  input  1  oversampling strobe, one clk_i cycle wide, 16 per bit period
- dout_o  output  Nbits  last received word, held until next frame completes
- rdy_o  output  1  one-cycle pulse: dout_o/err flags updated
- frm_err_o  output  1  stop bit sampled 0 on the frame flagged by rdy_o; held until next rdy_o
- par_err_o  output  1  parity error (see Optional Feature); held until next rdy_o

Behaviour:
- Reset (rst_ni=0, async): state=IDLE; s=0, n=0, shift=0; sync flops=1; dout_o=0, rdy_o=0, frm_err_o=0, par_err_o=0.
- rx_i passes through a 2-flop synchroniser (reset value 1) -> rx_s. All decisions use rx_s only. This adds 2 clk_i latency.
- Counters: s 4-bit tick counter; n 3-bit bit index; shift Nbits-bit register. All outputs are registered.
- IDLE: when rx_s==0, go to START with s=0. tick_i is ignored in IDLE.
- START: on tick_i, if s==7 (mid start bit):
  - rx_s==0 -> DATA, s=0, n=0.
  - rx_s==1 -> false start; return to IDLE with no rdy_o.
  - Otherwise s=s+1.
- DATA: on tick_i, if s==15:
  - shift={rx_s, shift[Nbits-1:1]} (LSB first), s=0.
  - If n==Nbits-1 -> PARITY (feature on) or STOP; else n=n+1.
  - Otherwise s=s+1.
- STOP: on tick_i, if s==Sticks-1:
  - next cycle: dout_o=shift, frm_err_o=~rx_s, rdy_o=1 for exactly one clk_i, state=IDLE, s=0.
  - Otherwise s=s+1.
- Without tick_i, no counter advances in START/DATA/STOP.
- rdy_o pulses once per completed frame, including frames with framing error. dout_o is updated even on framing error.
- Back-to-back frames: a new start edge is detected from IDLE on the cycle after STOP completes. No dead ticks are required beyond the stop sample.
- Break condition (rx_s held 0): each frame completes with frm_err_o=1 and dout_o=0. The receiver then re-enters START immediately, since rx_s is still 0.
- Reset asserted mid-frame: abort and return to reset values; no rdy_o is generated for the partial frame.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds PARITY state after DATA. On tick_i with s==15, it samples the parity bit and computes even parity: err = ^shift ^ rx_s. It then sets s=0 and goes to STOP.
  - par_err_o is loaded with err together with dout_o on rdy_o.
- Undefined:
  - No PARITY state; DATA goes directly to STOP.
  - par_err_o is constant 0.

Test Plan:
- tick_i every 4 clk_i; send 0xA5 with good stop -> dout_o=0xA5, single rdy_o pulse, frm_err_o=0, par_err_o=0.
- rx_i low for 4 ticks then high (glitch) -> state back to IDLE, no rdy_o, dout_o unchanged from 0x00.
- Send 0x3C with stop bit driven 0 -> rdy_o pulse, dout_o=0x3C, frm_err_o=1. A following good 0x00 frame -> frm_err_o=0.
- Back-to-back 0x00 then 0xFF with no idle gap -> two rdy_o pulses, dout_o=0x00 then 0xFF.
- rst_ni pulsed low during bit 3 of 0x55, then send 0x81 -> no rdy_o for the aborted frame; next rdy_o has dout_o=0x81.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> par_err_o=0; with parity bit 0 -> par_err_o=1.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: UART receive path. Deserialises an asynchronous serial line
// (1 start, Nbits data LSB-first, [1 even-parity], 1 stop) using an external
// oversampling strobe of 16 ticks per bit period.
//
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit after
// the data bits and drives par_err_o; when undefined par_err_o is tied 0).
//
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous reset, active-low
//   rx_i       serial line, idle high, asynchronous to clk_i
//   tick_i     oversampling strobe, one clk_i wide, 16 per bit period
//   dout_o     last received word, held until the next frame completes
//   rdy_o      one-cycle pulse: dout_o and error flags were just updated
//   frm_err_o  stop bit sampled 0 on the frame flagged by rdy_o
//   par_err_o  parity error on the frame flagged by rdy_o
module uart_receiver #(
  parameter int Nbits  = 8,
  parameter int Sticks = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_i,
  input  logic             tick_i,
  output logic [Nbits-1:0] dout_o,
  output logic             rdy_o,
  output logic             frm_err_o,
  output logic             par_err_o
);

  localparam logic [2:0] NLAST = 3'(Nbits - 1);
  localparam logic [3:0] SLAST = 4'(Sticks - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       s_q, s_d;
  logic [2:0]       n_q, n_d;
  logic [Nbits-1:0] shift_q, shift_d;
  logic             done;

  logic             rx_meta, rx_s;

  logic [Nbits-1:0] dout_d;
  logic             rdy_d, frm_d;

`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
  logic             par_out_d;
`endif

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // State, counters, datapath and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      shift_q   <= '0;
      dout_o    <= '0;
      rdy_o     <= 1'b0;
      frm_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      par_err_o <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      shift_q   <= shift_d;
      dout_o    <= dout_d;
      rdy_o     <= rdy_d;
      frm_err_o <= frm_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      par_err_o <= par_out_d;
`endif
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    done    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick_i) begin
          if (s_q == 4'd7) begin
            // Mid start bit: a high line here was only a glitch.
            s_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick_i) begin
          if (s_q == 4'd15) begin
            shift_d = {rx_s, shift_q[Nbits-1:1]};
            s_d     = '0;
            if (n_q == NLAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_i) begin
          if (s_q == 4'd15) begin
            par_d   = (^shift_q) ^ rx_s;
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
`endif
      STOP: begin
        if (tick_i) begin
          if (s_q == SLAST) begin
            done    = 1'b1;
            s_d     = '0;
            state_d = IDLE;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = '0;
      end
    endcase
  end

  // Output logic: results are loaded on the stop-bit sample and held.
  always_comb begin
    dout_d = dout_o;
    frm_d  = frm_err_o;
    rdy_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_out_d = par_err_o;
`endif
    if (done) begin
      rdy_d  = 1'b1;
      dout_d = shift_q;
      frm_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
      par_out_d = par_q;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign par_err_o = 1'b0;
`endif

endmodule
